// File: rtl/spram_arb_if.sv
// Bundle of requester handshakes, read-return and RAM pins shared by the spram arbiter.
// "master" is the environment side (requesters plus the RAM's read port); "slave" is the arbiter.
interface spram_arb_if #(
  parameter int ASIZE = 10,
  parameter int DSIZE = 32
);
  logic             wrVld;
  logic [ASIZE-1:0] wrAddr;
  logic [DSIZE-1:0] wrData;
  logic             wrRdy;
  logic             rdVld;
  logic [ASIZE-1:0] rdAddr;
  logic             rdRdy;
  logic             rdDataVld;
  logic [DSIZE-1:0] rdData;
  logic [ASIZE-1:0] ramAddr;
  logic [DSIZE-1:0] ramData;
  logic             ramCe;
  logic             ramWr;
  logic [DSIZE-1:0] ramRdata;
  logic [1:0]       grant;

  modport master (
    output wrVld, wrAddr, wrData, rdVld, rdAddr, ramRdata,
    input  wrRdy, rdRdy, rdDataVld, rdData, ramAddr, ramData, ramCe, ramWr, grant
  );

  modport slave (
    input  wrVld, wrAddr, wrData, rdVld, rdAddr, ramRdata,
    output wrRdy, rdRdy, rdDataVld, rdData, ramAddr, ramData, ramCe, ramWr, grant
  );
endinterface

// File: rtl/spram_arb.sv
// Round-robin, burst-bounded arbiter that shares one single-port RAM (1-cycle registered read)
// between a write requester and a read requester, with registered RAM pins and read-return strobe.
module spram_arb #(
  parameter int ASIZE     = 10,
  parameter int DSIZE     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  spram_arb_if.slave    bus
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lastRd_q, lastRd_d;

  logic             ramCe_q, ramWr_q, rdDataVld_q;
  logic [ASIZE-1:0] ramAddr_q;
  logic [DSIZE-1:0] ramData_q;

  logic             wrBeat, rdBeat;

  assign wrBeat = (state_q == GNT_WR) && bus.wrVld;
  assign rdBeat = (state_q == GNT_RD) && bus.rdVld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lastRd_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lastRd_q <= lastRd_d;
    end
  end

  // lastRd_q remembers the side that most recently gave up the RAM; IDLE contention favours the other one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lastRd_d = lastRd_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.wrVld && bus.rdVld) begin
          state_d = lastRd_q ? GNT_WR : GNT_RD;
        end else if (bus.wrVld) begin
          state_d = GNT_WR;
        end else if (bus.rdVld) begin
          state_d = GNT_RD;
        end
      end
      GNT_WR: begin
        if (!bus.wrVld) begin
          cnt_d    = '0;
          lastRd_d = 1'b0;
          state_d  = bus.rdVld ? GNT_RD : IDLE;
        end else if ((cnt_q == CNT_LAST) && bus.rdVld) begin
          cnt_d    = '0;
          lastRd_d = 1'b0;
          state_d  = GNT_RD;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GNT_RD: begin
        if (!bus.rdVld) begin
          cnt_d    = '0;
          lastRd_d = 1'b1;
          state_d  = bus.wrVld ? GNT_WR : IDLE;
        end else if ((cnt_q == CNT_LAST) && bus.wrVld) begin
          cnt_d    = '0;
          lastRd_d = 1'b1;
          state_d  = GNT_WR;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // rdDataVld_q trails a registered read command by one cycle, matching the RAM's output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ramCe_q     <= 1'b0;
      ramWr_q     <= 1'b0;
      ramAddr_q   <= '0;
      ramData_q   <= '0;
      rdDataVld_q <= 1'b0;
    end else begin
      rdDataVld_q <= ramCe_q && !ramWr_q;
      ramCe_q     <= wrBeat || rdBeat;
      ramWr_q     <= wrBeat;
      if (wrBeat) begin
        ramAddr_q <= bus.wrAddr;
        ramData_q <= bus.wrData;
      end else if (rdBeat) begin
        ramAddr_q <= bus.rdAddr;
      end
    end
  end

  assign bus.wrRdy     = (state_q == GNT_WR);
  assign bus.rdRdy     = (state_q == GNT_RD);
  assign bus.grant     = {state_q == GNT_RD, state_q == GNT_WR};
  assign bus.ramCe     = ramCe_q;
  assign bus.ramWr     = ramWr_q;
  assign bus.ramAddr   = ramAddr_q;
  assign bus.ramData   = ramData_q;
  assign bus.rdDataVld = rdDataVld_q;
  assign bus.rdData    = bus.ramRdata;

endmodule

// File: tb/tb_spram_arb.sv
// Bench for spram_arb with MAX_BURST=4: RAM model, shadow-memory scoreboard for read data,
// and per-scenario tasks checking grants, RAM pin timing and reset behaviour.
module tb_spram_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];
  logic [31:0] expQ   [$];

  always #5 clk = ~clk;

  spram_arb_if #(.ASIZE(10), .DSIZE(32)) bus ();

  spram_arb #(.ASIZE(10), .DSIZE(32), .MAX_BURST(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Single-port RAM with a registered read port, driven only by the arbiter's registered pins.
  always @(posedge clk) begin
    if (bus.ramCe) begin
      if (bus.ramWr) mem[bus.ramAddr] <= bus.ramData;
      else           bus.ramRdata <= mem[bus.ramAddr];
    end
  end

  // Scoreboard: accepted writes update the shadow, accepted reads queue the value they must return.
  always @(negedge clk) begin
    logic [31:0] expWord;
    if (rst) begin
      expQ.delete();
    end else begin
      if (bus.rdDataVld) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sb_spurious_rd: rdDataVld=1 data=%h, required no pending read", bus.rdData);
        end else begin
          expWord = expQ.pop_front();
          if (bus.rdData !== expWord) begin
            mismatched++;
            $display("[TB] FAIL sb_rd_data: got %h required %h", bus.rdData, expWord);
          end
        end
      end
      if (bus.wrVld && bus.wrRdy) shadow[bus.wrAddr] = bus.wrData;
      if (bus.rdVld && bus.rdRdy) expQ.push_back(shadow[bus.rdAddr]);
    end
  end

  task automatic test_reset;
    @(negedge clk);
    compared++;
    if ({bus.wrRdy, bus.rdRdy, bus.rdDataVld, bus.ramCe, bus.ramWr, bus.grant} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b required 0", {bus.wrRdy, bus.rdRdy, bus.rdDataVld, bus.ramCe, bus.ramWr, bus.grant});
    end
    compared++;
    if ({bus.ramAddr, bus.ramData} !== 42'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: addr=%h data=%h required 0", bus.ramAddr, bus.ramData);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.grant !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_idle_grant: got %b required 00", bus.grant);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst;
    logic [1:0] want;
    logic accW, accR;
    bus.wrAddr = 10'h100; bus.wrData = $urandom; bus.rdAddr = 10'h100;
    bus.wrVld = 1'b1; bus.rdVld = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      want = (k == 0) ? 2'b00 : ((((k - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10);
      compared++;
      if (bus.grant !== want) begin
        mismatched++;
        $display("[TB] FAIL burst_grant[%0d]: got %b required %b", k, bus.grant, want);
      end
      compared++;
      if ({bus.ramCe, bus.ramWr} !== {k >= 2, (k >= 2) && (((k - 2) / 4) % 2 == 0)}) begin
        mismatched++;
        $display("[TB] FAIL burst_ram_pins[%0d]: got ce=%b wr=%b", k, bus.ramCe, bus.ramWr);
      end
      accW = bus.wrVld && bus.wrRdy;
      accR = bus.rdVld && bus.rdRdy;
      @(posedge clk); #1;
      if (accW) begin bus.wrAddr++; bus.wrData = $urandom; end
      if (accR) bus.rdAddr++;
    end
    bus.wrVld = 1'b0; bus.rdVld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    bus.wrAddr = 10'h5; bus.wrData = 32'hDEADBEEF; bus.wrVld = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.wrRdy) break;
    end
    compared++;
    if (bus.wrRdy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_wr_accept: wrRdy=%b required 1 within 10 cycles", bus.wrRdy);
    end
    @(posedge clk); #1 bus.wrVld = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.ramCe, bus.ramWr, bus.ramAddr, bus.ramData} !== {1'b1, 1'b1, 10'h5, 32'hDEADBEEF}) begin
      mismatched++;
      $display("[TB] FAIL single_wr_pins: ce=%b wr=%b addr=%h data=%h required 1 1 005 deadbeef",
               bus.ramCe, bus.ramWr, bus.ramAddr, bus.ramData);
    end
    @(negedge clk);
    compared++;
    if ({bus.ramCe, bus.ramWr} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL single_wr_pulse: ce=%b wr=%b required 0 0", bus.ramCe, bus.ramWr);
    end
    @(posedge clk); #1 bus.rdAddr = 10'h5; bus.rdVld = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.rdRdy) break;
    end
    compared++;
    if (bus.rdRdy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_rd_accept: rdRdy=%b required 1 within 10 cycles", bus.rdRdy);
    end
    @(posedge clk); #1 bus.rdVld = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.ramCe, bus.ramWr, bus.ramAddr, bus.rdDataVld} !== {1'b1, 1'b0, 10'h5, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL single_rd_pins: ce=%b wr=%b addr=%h rdv=%b required 1 0 005 0",
               bus.ramCe, bus.ramWr, bus.ramAddr, bus.rdDataVld);
    end
    @(negedge clk);
    compared++;
    if ({bus.rdDataVld, bus.rdData} !== {1'b1, 32'hDEADBEEF}) begin
      mismatched++;
      $display("[TB] FAIL single_rd_data: vld=%b data=%h required 1 deadbeef", bus.rdDataVld, bus.rdData);
    end
    @(negedge clk);
    compared++;
    if (bus.rdDataVld !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_rd_vld_pulse: got %b required 0", bus.rdDataVld);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rd_stream;
    int  acc = 0, vcnt = 0;
    int  firstAcc = -1, lastAcc = -1, firstV = -1, lastV = -1;
    logic accR;
    bus.rdAddr = 10'h0; bus.rdVld = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rdDataVld) begin
        if (firstV < 0) firstV = c;
        lastV = c;
        vcnt++;
      end
      accR = bus.rdVld && bus.rdRdy;
      if (accR) begin
        if (firstAcc < 0) firstAcc = c;
        lastAcc = c;
        acc++;
      end
      @(posedge clk); #1;
      if (accR) begin
        if (acc == 20) bus.rdVld = 1'b0;
        else           bus.rdAddr++;
      end
    end
    bus.rdVld = 1'b0;
    compared++;
    if (acc !== 20 || lastAcc - firstAcc !== 19) begin
      mismatched++;
      $display("[TB] FAIL stream_accepts: got %0d over span %0d required 20 over 19", acc, lastAcc - firstAcc);
    end
    compared++;
    if (vcnt !== 20 || lastV - firstV !== 19) begin
      mismatched++;
      $display("[TB] FAIL stream_rd_vld: got %0d over span %0d required 20 over 19", vcnt, lastV - firstV);
    end
    compared++;
    if (firstV - firstAcc !== 2) begin
      mismatched++;
      $display("[TB] FAIL stream_latency: got %0d required 2", firstV - firstAcc);
    end
  endtask

  task automatic test_switch;
    int beats = 0;
    logic accW;
    logic [1:0] want;
    bus.wrAddr = 10'h40; bus.wrData = $urandom; bus.rdAddr = 10'h200;
    bus.wrVld = 1'b1; bus.rdVld = 1'b0;
    for (int c = 0; c < 10 && beats < 2; c++) begin
      @(negedge clk);
      accW = bus.wrVld && bus.wrRdy;
      @(posedge clk); #1;
      if (accW) begin beats++; bus.wrAddr++; bus.wrData = $urandom; end
    end
    compared++;
    if (beats !== 2) begin
      mismatched++;
      $display("[TB] FAIL switch_wr_beats: got %0d required 2", beats);
    end
    bus.wrVld = 1'b0; bus.rdVld = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.grant !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL switch_hold_wr: got %b required 01", bus.grant);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      want = (k <= 3) ? 2'b10 : 2'b01;
      compared++;
      if (bus.grant !== want) begin
        mismatched++;
        $display("[TB] FAIL switch_rd_burst[%0d]: got %b required %b", k, bus.grant, want);
      end
      @(posedge clk); #1;
      if (k == 0) bus.wrVld = 1'b1;
      if (k <= 3) bus.rdAddr++;
      if (k == 4) begin bus.wrVld = 1'b0; bus.rdVld = 1'b0; end
    end
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({bus.grant, bus.wrRdy, bus.rdRdy} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL switch_idle: grant=%b wrRdy=%b rdRdy=%b required 00 0 0", bus.grant, bus.wrRdy, bus.rdRdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream;
    bus.wrAddr = 10'h300; bus.wrData = 32'h12345678; bus.rdAddr = 10'h300;
    bus.wrVld = 1'b1; bus.rdVld = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    bus.wrVld = 1'b0; bus.rdVld = 1'b0;
    #1;
    compared++;
    if ({bus.wrRdy, bus.rdRdy, bus.rdDataVld, bus.ramCe, bus.ramWr, bus.grant} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_ctrl: got %b required 0", {bus.wrRdy, bus.rdRdy, bus.rdDataVld, bus.ramCe, bus.ramWr, bus.grant});
    end
    compared++;
    if ({bus.ramAddr, bus.ramData} !== 42'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_bus: addr=%h data=%h required 0", bus.ramAddr, bus.ramData);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compared++;
      if ({bus.rdDataVld, bus.ramCe} !== 2'b00) begin
        mismatched++;
        $display("[TB] FAIL midrst_after[%0d]: rdv=%b ce=%b required 0 0", c, bus.rdDataVld, bus.ramCe);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_after_read;
    bus.rdAddr = 10'h7; bus.rdVld = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.rdRdy) break;
    end
    compared++;
    if (bus.rdRdy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstrd_accept: rdRdy=%b required 1 within 10 cycles", bus.rdRdy);
    end
    @(posedge clk); #2;
    bus.rdVld = 1'b0; rst = 1'b1;
    #1;
    compared++;
    if ({bus.ramCe, bus.rdDataVld} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL rstrd_ce: ce=%b rdv=%b required 0 0", bus.ramCe, bus.rdDataVld);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    bus.wrAddr = 10'h60; bus.wrData = 32'hCAFEF00D; bus.rdAddr = 10'h61;
    bus.wrVld = 1'b1; bus.rdVld = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (bus.rdDataVld !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rstrd_no_vld[%0d]: got %b required 0", c, bus.rdDataVld);
      end
      if (c < 2) begin
        compared++;
        if (bus.grant !== ((c == 0) ? 2'b00 : 2'b01)) begin
          mismatched++;
          $display("[TB] FAIL rstrd_first_grant[%0d]: got %b required %b", c, bus.grant, (c == 0) ? 2'b00 : 2'b01);
        end
      end
    end
    @(posedge clk); #1;
    bus.wrVld = 1'b0; bus.rdVld = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'hA5000000 | 32'(i);
      shadow[i] = 32'hA5000000 | 32'(i);
    end
    bus.ramRdata = '0;
    bus.wrVld = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    bus.rdVld = 1'b0; bus.rdAddr = '0;

    test_reset;
    test_burst;
    test_single;
    test_rd_stream;
    test_switch;
    test_reset_midstream;
    test_rst_after_read;

    repeat (6) @(negedge clk);
    compared++;
    if (expQ.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL sb_drain: %0d reads never returned, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
